// File: rtl/proc_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for the exec stage.
package proc_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1000;
  localparam logic [3:0] OP_NOP = 4'b1111;

  typedef enum logic [1:0] {IDLE, OPERAND, EXEC} state_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_O = 0;

  // True for opcodes that retire a register write (ALU ops and LDI).
  function automatic logic op_writes(input logic [3:0] op);
    return (op <= OP_LDI);
  endfunction

  // True for the register-register ALU ops that also update Z/N.
  function automatic logic op_is_alu(input logic [3:0] op);
    return (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/exec_stage_if.sv
// Instruction handshake, ALU bus, write-back and debug signals of the exec stage.
interface exec_stage_if #(
  parameter int W  = 16,
  parameter int AW = 3
);
  logic          instr_valid;
  logic          instr_ready;
  logic [15:0]   instr;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [3:0]    alu_op;
  logic [W-1:0]  alu_result;
  logic          alu_z;
  logic          alu_n;
  logic          alu_c;
  logic          alu_o;
  logic [3:0]    flags;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;
  logic          busy;

  // Environment side: instruction source, ALU and debug reader.
  modport master (
    output instr_valid, instr, alu_result, alu_z, alu_n, alu_c, alu_o, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_op, flags, wb_valid, wb_addr, wb_data,
           dbg_data, busy
  );

  // Stage side.
  modport slave (
    input  instr_valid, instr, alu_result, alu_z, alu_n, alu_c, alu_o, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_op, flags, wb_valid, wb_addr, wb_data,
           dbg_data, busy
  );
endinterface

// File: rtl/regfile.sv
// Register file: two operand read ports, one debug read port, one write port, r0 reads zero.
module regfile #(
  parameter int NREGS = 8,
  parameter int W     = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_ra,
  input  logic [AW-1:0] i_rb,
  input  logic [AW-1:0] i_rdbg,
  input  logic          i_we,
  input  logic [AW-1:0] i_wa,
  input  logic [W-1:0]  i_wd,
  output logic [W-1:0]  o_rda,
  output logic [W-1:0]  o_rdb,
  output logic [W-1:0]  o_rdbg
);

  logic [NREGS-1:0][W-1:0] w_regs;

  // r0 has no storage; writes to it are simply dropped.
  assign w_regs[0] = '0;

  for (genvar g = 1; g < NREGS; g++) begin : g_reg
    logic [W-1:0] r_q;
    // One storage word per architectural register, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          r_q <= '0;
      else if (i_we && (i_wa == AW'(g)))   r_q <= i_wd;
    end
    assign w_regs[g] = r_q;
  end

  assign o_rda  = w_regs[i_ra];
  assign o_rdb  = w_regs[i_rb];
  assign o_rdbg = w_regs[i_rdbg];

endmodule

// File: rtl/exec_stage.sv
// Three-cycle operand-fetch / write-back sequencer in front of a combinational ALU.
module exec_stage
  import proc_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int W     = 16
) (
  input logic         clk,
  input logic         rst_n,
  exec_stage_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  state_t         r_state;
  logic [15:0]    r_instr;
  logic [W-1:0]   r_alu_a;
  logic [W-1:0]   r_alu_b;
  logic [3:0]     r_alu_op;
  logic [3:0]     r_flags;

  logic [3:0]     w_op;
  logic [AW-1:0]  w_rd;
  logic [AW-1:0]  w_rs;
  logic [AW-1:0]  w_rt;
  logic [8:0]     w_imm9;
  logic [W-1:0]   w_rs_data;
  logic [W-1:0]   w_rt_data;
  logic           w_we;

  assign w_op   = r_instr[15:12];
  assign w_rd   = r_instr[11:9];
  assign w_rs   = r_instr[8:6];
  assign w_rt   = r_instr[5:3];
  assign w_imm9 = r_instr[8:0];

  // Write happens on the edge leaving EXEC; r0 writes still strobe wb_valid.
  assign w_we = (r_state == EXEC) && op_writes(w_op);

  regfile #(.NREGS(NREGS), .W(W), .AW(AW)) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_ra   (w_rs),
    .i_rb   (w_rt),
    .i_rdbg (bus.dbg_addr),
    .i_we   (w_we),
    .i_wa   (w_rd),
    .i_wd   (bus.alu_result),
    .o_rda  (w_rs_data),
    .o_rdb  (w_rt_data),
    .o_rdbg (bus.dbg_data)
  );

  // Sequencer: accept in IDLE, fetch operands in OPERAND, retire flags in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_instr  <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= OP_NOP;
      r_flags  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.instr_valid) begin
            r_instr <= bus.instr;
            r_state <= OPERAND;
          end
        end
        OPERAND: begin
          if (op_is_alu(w_op)) begin
            r_alu_a  <= w_rs_data;
            r_alu_b  <= w_rt_data;
            r_alu_op <= w_op;
          end else if (w_op == OP_LDI) begin
            // LDI is routed through the ALU as 0 | imm9.
            r_alu_a  <= '0;
            r_alu_b  <= {{(W-9){1'b0}}, w_imm9};
            r_alu_op <= OP_OR;
          end else begin
            // Reserved ops: ALU yields 0, operands are left as they were.
            r_alu_op <= w_op;
          end
          r_state <= EXEC;
        end
        EXEC: begin
          if (op_is_alu(w_op)) begin
            r_flags[FLAG_Z] <= bus.alu_z;
            r_flags[FLAG_N] <= bus.alu_n;
          end
          // The ALU's C/O are only meaningful for ADD/SUB.
          if (w_op == OP_ADD || w_op == OP_SUB) begin
            r_flags[FLAG_C] <= bus.alu_c;
            r_flags[FLAG_O] <= bus.alu_o;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.instr_ready = (r_state == IDLE);
  assign bus.busy        = (r_state != IDLE);
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_op      = r_alu_op;
  assign bus.flags       = r_flags;
  assign bus.wb_valid    = w_we;
  assign bus.wb_addr     = w_rd;
  assign bus.wb_data     = bus.alu_result;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage with a behavioural ALU stub on the ALU bus.
module tb_exec_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   wb_cnt = 0;

  exec_stage_if #(.W(16), .AW(3)) bus ();

  exec_stage #(.NREGS(8), .W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ALU stub. SUB reports C as borrow and O as "sign of result differs from A";
  // the stage must latch whatever the ALU reports.
  logic [16:0] alu_sum;
  logic [15:0] alu_r;
  always_comb begin
    alu_sum = 17'h0;
    alu_r   = 16'h0;
    bus.alu_c = 1'b0;
    bus.alu_o = 1'b0;
    case (bus.alu_op)
      4'h0: begin
        alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        alu_r = alu_sum[15:0];
        bus.alu_c = alu_sum[16];
        bus.alu_o = (bus.alu_a[15] == bus.alu_b[15]) && (alu_r[15] != bus.alu_a[15]);
      end
      4'h1: begin
        alu_sum = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        alu_r = alu_sum[15:0];
        bus.alu_c = alu_sum[16];
        bus.alu_o = (alu_r[15] != bus.alu_a[15]);
      end
      4'h2: alu_r = bus.alu_a & bus.alu_b;
      4'h3: alu_r = bus.alu_a | bus.alu_b;
      4'h4: alu_r = bus.alu_a ^ bus.alu_b;
      4'h5: alu_r = ~bus.alu_a;
      4'h6: alu_r = bus.alu_a << bus.alu_b[3:0];
      4'h7: alu_r = bus.alu_a >> bus.alu_b[3:0];
      default: alu_r = 16'h0;
    endcase
    bus.alu_result = alu_r;
    bus.alu_z = (alu_r == 16'h0);
    bus.alu_n = alu_r[15];
  end

  // Count completed write-back edges.
  always @(posedge clk) if (rst_n && bus.wb_valid) wb_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rd_reg(input logic [2:0] a, input logic [15:0] exp, input string tag);
    bus.dbg_addr = a;
    #1;
    chk(tag, bus.dbg_data, exp);
  endtask

  // Issue one instruction from IDLE and walk it through OPERAND and EXEC.
  task automatic run(input string tag, input logic [15:0] ins, input logic exp_wb);
    int n = 0;
    while (!bus.instr_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, " ready"}, bus.instr_ready, 1);
    bus.instr_valid = 1'b1;
    bus.instr = ins;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk({tag, " operand wb"}, bus.wb_valid, 0);
    @(negedge clk);
    chk({tag, " exec wb"}, bus.wb_valid, exp_wb);
    @(negedge clk);
  endtask

  int acc[$];

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0;
    bus.dbg_addr = 3'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst flags", bus.flags, 4'h0);
    chk("rst ready", bus.instr_ready, 1);
    chk("rst alu_op", bus.alu_op, 4'hF);
    chk("rst alu_a", bus.alu_a, 16'h0);
    chk("rst wb_addr", bus.wb_addr, 3'd0);

    // LDI r1,0x100 ; LDI r2,0x1FF ; ADD r3,r1,r2
    wb_cnt = 0;
    run("ldi r1", 16'h8300, 1'b1);
    run("ldi r2", 16'h85FF, 1'b1);
    run("add r3", 16'h0650, 1'b1);
    chk("wb count", wb_cnt, 3);
    rd_reg(3'd1, 16'h0100, "r1");
    rd_reg(3'd2, 16'h01FF, "r2");
    rd_reg(3'd3, 16'h02FF, "r3");
    chk("add flags", bus.flags, 4'b0000);

    // SUB r4,r1,r2
    run("sub r4", 16'h1850, 1'b1);
    rd_reg(3'd4, 16'hFF01, "r4");
    chk("sub flags", bus.flags, 4'b0111);

    // XOR r5,r1,r1 keeps C/O
    run("xor r5", 16'h4A48, 1'b1);
    rd_reg(3'd5, 16'h0000, "r5");
    chk("xor flags", bus.flags, 4'b1011);

    // Reserved op 1010 targeting r1: no write, flags held
    run("nop", 16'hA200, 1'b0);
    chk("nop alu_op", bus.alu_op, 4'hA);
    chk("nop flags", bus.flags, 4'b1011);
    rd_reg(3'd1, 16'h0100, "nop r1");

    // ADD r0,r1,r2: strobe seen, r0 unchanged
    bus.instr_valid = 1'b1;
    bus.instr = 16'h0050;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("r0 wb_valid", bus.wb_valid, 1);
    chk("r0 wb_addr", bus.wb_addr, 3'd0);
    chk("r0 wb_data", bus.wb_data, 16'h02FF);
    @(negedge clk);
    rd_reg(3'd0, 16'h0000, "r0");
    chk("r0 flags", bus.flags, 4'b0000);

    // Back-to-back: valid held high, acceptances every third cycle
    bus.instr = 16'h8E55;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (bus.instr_ready) acc.push_back(i);
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    chk("acc count", acc.size(), 3);
    if (acc.size() == 3) begin
      chk("acc gap0", acc[1] - acc[0], 3);
      chk("acc gap1", acc[2] - acc[1], 3);
    end
    rd_reg(3'd7, 16'h0055, "r7");

    // Reset during EXEC of ADD r6,r1,r2
    run("pre", 16'h8000, 1'b1);
    bus.instr_valid = 1'b1;
    bus.instr = 16'h0C50;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("r6 exec wb", bus.wb_valid, 1);
    wb_cnt = 0;
    rst_n = 1'b0;
    #1;
    chk("rst wb_valid", bus.wb_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst wb count", wb_cnt, 0);
    chk("rst2 flags", bus.flags, 4'h0);
    chk("rst2 ready", bus.instr_ready, 1);
    chk("rst2 alu_op", bus.alu_op, 4'hF);
    for (int a = 0; a < 8; a++) rd_reg(3'(a), 16'h0000, "rst2 reg");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
# exec_stage

Operand-fetch and write-back stage that sits directly upstream of the combinational `ALU`. It accepts one 16-bit instruction per valid/ready handshake and reads operands from an internal 8×16 register file. It presents registered A/B/opcode to the ALU, then writes the ALU result and flags back. It is a multi-cycle, non-pipelined sequencer that retires one instruction every three cycles.

## Interface
Parameters:
- `NREGS`, 8: register count; address width is log2(NREGS) = 3.
- `W`, 16: datapath width; must match the ALU.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `instr_valid`  in  1  upstream has an instruction.
- `instr_ready`  out  1  stage can accept; high only in IDLE.
- `instr`  in  16  instruction: [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [8:0] imm9 (LDI only).
- `alu_a`  out  16  registered operand A to the ALU.
- `alu_b`  out  16  registered operand B to the ALU.
- `alu_op`  out  4  registered ALU opcode.
- `alu_result`  in  16  ALU result.
- `alu_z`, `alu_n`, `alu_c`, `alu_o`  in  1 each  ALU flags.
- `flags`  out  4  architectural flags {Z,N,C,O}.
- `wb_valid`  out  1  write-back strobe, high for the whole EXEC cycle of a writing instruction.
- `wb_addr`  out  3  destination register.
- `wb_data`  out  16  value written; equals `alu_result`.
- `dbg_addr`  in  3  debug read address.
- `dbg_data`  out  16  combinational read of register `dbg_addr`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Three FSM states:
  - IDLE: on `instr_valid && instr_ready`, latch `instr` and go to OPERAND. Otherwise stay in IDLE.
  - OPERAND: register operands for op 0000–0111, then go to EXEC.
    - `alu_a <= rf[rs]`, `alu_b <= rf[rt]`, `alu_op <= op`.
  - EXEC: ALU outputs are valid. On the exiting edge, perform write-back and flag update, then go to IDLE.
- LDI (op 1000), in OPERAND:
  - `alu_a <= 0`, `alu_b <= {7'b0, imm9}`, `alu_op <= 4'b0011` (OR).
  - The result therefore passes through the ALU.
- Write-back:
  - Op 0000–1000: `rf[rd] <= alu_result`, with `wb_valid` high.
  - Op 1001–1111: reserved NOP. Set `alu_op <= op` (ALU outputs 0), `wb_valid` low, no register write, no flag change.
- r0 is hardwired to zero and always reads 0. A write to r0 still asserts `wb_valid` with `wb_addr = 0`, but the register file is unchanged.
- Flag update:
  - Z and N: updated for op 0000–0111.
  - C: updated only for ADD/SUB (0000/0001), because the ALU's C is undefined for other ops.
  - O: updated only for ADD/SUB; the value is latched exactly as the ALU reports it.
  - LDI and NOP change no flags.
- Reset, from any state including mid-EXEC:
  - State → IDLE.
  - All registers → 0, `flags` → 0.
  - `alu_a` = `alu_b` = 0, `alu_op` = 4'b1111.
  - `wb_valid` = 0, `wb_addr` = 0, `wb_data` follows `alu_result`.
  - A pending write-back is discarded.

## Timing
- Cycle 0: handshake edge.
- Cycle 1: OPERAND; operands are registered at the end of the cycle.
- Cycle 2: EXEC; ALU inputs are stable, `wb_valid` is high, and the RF write and flag update occur at the end of the cycle.
- Cycle 3: IDLE; `instr_ready` is high again and the next handshake can occur.
- Throughput: 1 instruction per 3 cycles. With `instr_valid` held high continuously, `instr_ready` pulses once every third cycle.
- No forwarding is needed. The next instruction's OPERAND cycle falls after the previous write edge, so it reads the updated value.
- `dbg_data` reflects a write on the cycle after the write edge.
- `alu_a`, `alu_b` and `alu_op` hold their values outside OPERAND.

## Structure
- Package `proc_pkg`:
  - Opcode constants: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_LDI, OP_NOP = 4'b1111.
  - State enum {IDLE, OPERAND, EXEC}.
  - Flag bit indices FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_O=0.
- Sub-module `regfile`: 2 combinational read ports, 1 debug read port, 1 synchronous write port, r0 tied to zero, async active-low clear.

## Test plan
- Reset behaviour: assert `rst_n` = 0 mid-stream → `flags` = 0, `instr_ready` = 1, `alu_op` = 4'b1111, `dbg_data` = 0 for all addresses.
- LDI then ADD:
  - LDI r1,0x100; LDI r2,0x1FF; ADD r3,r1,r2.
  - Expect r3 = 0x02FF, `flags` = 4'b0000, and `wb_valid` exactly 3 times, each in EXEC.
- SUB after the same loads: SUB r4,r1,r2 → r4 = 0xFF01, `flags` = {Z0,N1,C1,O1}.
- Logic op keeps C/O:
  - After the SUB, XOR r5,r1,r1 → r5 = 0 and `flags` = {1,0,1,1}.
  - C and O are held; Z and N are updated.
- r0 write and NOP:
  - ADD r0,r1,r2 → `wb_valid` = 1, `wb_addr` = 0, r0 still 0.
  - Op 1010 → `wb_valid` = 0, flags unchanged.
- Handshake and reset during EXEC:
  - Hold `instr_valid` high → acceptances exactly 3 cycles apart.
  - Assert `rst_n` during EXEC of ADD r6 → r6 stays 0 and no `wb_valid` edge completes.
